// File: rtl/regfile_scoreboard_pkg.sv
// Shared types and constants for the register file / scoreboard slice.
//   word_t    : default-width data word
//   regbits_t : one bit per architectural register (default count)
//   sb_tag_t  : scoreboard reservation tag (default width)
//   ZERO_REG  : index of the hardwired-zero register
package regfile_scoreboard_pkg;
  localparam int unsigned DW_DEF    = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned TAGW_DEF  = 4;
  localparam int unsigned ZERO_REG  = 0;

  typedef logic [DW_DEF-1:0]    word_t;
  typedef logic [NREGS_DEF-1:0] regbits_t;
  typedef logic [TAGW_DEF-1:0]  sb_tag_t;
endpackage

// File: rtl/regfile_sb_entry.sv
// One scoreboard entry: busy bit plus the tag of the owning writer.
//   CLK, nRST  : clock, async active-low reset
//   i_set      : reserve this register (takes priority over clear/flush)
//   i_set_tag  : tag stored with the reservation
//   i_clr      : qualified writeback clear (tag already matched)
//   i_flush    : clear busy unconditionally
//   o_busy     : current busy bit
//   o_tag      : current owner tag
module regfile_sb_entry
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned TAGW = TAGW_DEF
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            i_set,
  input  logic [TAGW-1:0] i_set_tag,
  input  logic            i_clr,
  input  logic            i_flush,
  output logic            o_busy,
  output logic [TAGW-1:0] o_tag
);
  logic            r_busy;
  logic [TAGW-1:0] r_tag;

  // A reservation in the same cycle as a clear or flush belongs to a newer
  // instruction, so it wins; the tag is kept on clear for debug visibility.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_busy <= 1'b0;
      r_tag  <= '0;
    end else if (i_set) begin
      r_busy <= 1'b1;
      r_tag  <= i_set_tag;
    end else if (i_clr || i_flush) begin
      r_busy <= 1'b0;
    end
  end

  assign o_busy = r_busy;
  assign o_tag  = r_tag;
endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised multi-port register file with write-to-read bypass and a
// per-register busy/tag scoreboard. Register 0 is hardwired to zero.
//   CLK, nRST         : clock, async active-low reset
//   rsel / rdat/rbusy : NRD read ports (combinational data and busy)
//   wen/wsel/wdat     : NWR write ports, highest index wins on collision
//   wclr/wtag         : release scoreboard entry if the tag still owns it
//   rsv_en/sel/tag    : reserve a destination register at decode
//   flush             : clear all busy bits (reservation still applied)
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 2,
  parameter int unsigned TAGW  = TAGW_DEF,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [NRD-1:0][AW-1:0]    rsel,
  output logic [NRD-1:0][DW-1:0]    rdat,
  output logic [NRD-1:0]            rbusy,
  input  logic [NWR-1:0]            wen,
  input  logic [NWR-1:0][AW-1:0]    wsel,
  input  logic [NWR-1:0][DW-1:0]    wdat,
  input  logic [NWR-1:0]            wclr,
  input  logic [NWR-1:0][TAGW-1:0]  wtag,
  input  logic                      rsv_en,
  input  logic [AW-1:0]             rsv_sel,
  input  logic [TAGW-1:0]           rsv_tag,
  input  logic                      flush
);
  logic [DW-1:0]   r_regs [NREGS];
  logic [NREGS-1:0] w_busy;
  logic [TAGW-1:0] w_tag  [NREGS];
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_clr;

  // Register array; ascending port loop makes the highest port win.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned r = 0; r < NREGS; r++) r_regs[r] <= '0;
    end else begin
      for (int unsigned p = 0; p < NWR; p++) begin
        if (wen[p] && (wsel[p] != AW'(ZERO_REG))) r_regs[wsel[p]] <= wdat[p];
      end
    end
  end

  // Per-register reserve and qualified clear requests.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      w_set[r] = rsv_en && (rsv_sel == AW'(r));
      for (int unsigned p = 0; p < NWR; p++) begin
        if (wen[p] && wclr[p] && (wsel[p] == AW'(r)) && w_busy[r] &&
            (w_tag[r] == wtag[p]))
          w_clr[r] = 1'b1;
      end
    end
  end

  assign w_busy[0] = 1'b0;
  assign w_tag[0]  = '0;

  for (genvar g = 1; g < NREGS; g++) begin : g_sb
    regfile_sb_entry #(.TAGW(TAGW)) u_entry (
      .CLK       (CLK),
      .nRST      (nRST),
      .i_set     (w_set[g]),
      .i_set_tag (rsv_tag),
      .i_clr     (w_clr[g]),
      .i_flush   (flush),
      .o_busy    (w_busy[g]),
      .o_tag     (w_tag[g])
    );
  end

  // Read ports: array value, overridden by enabled writers in port order so
  // the highest matching port lands last. Busy is masked by a same-cycle
  // clear unless a same-cycle reservation re-claims the register.
  always_comb begin
    rdat  = '0;
    rbusy = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      rdat[i] = r_regs[rsel[i]];
      for (int unsigned p = 0; p < NWR; p++) begin
        if (wen[p] && (wsel[p] == rsel[i])) rdat[i] = wdat[p];
      end
      rbusy[i] = w_busy[rsel[i]] && !(w_clr[rsel[i]] && !w_set[rsel[i]]);
      if (rsel[i] == AW'(ZERO_REG)) begin
        rdat[i]  = '0;
        rbusy[i] = 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;
  logic             CLK = 1'b0;
  logic             nRST;
  logic [1:0][4:0]  rsel;
  logic [1:0][31:0] rdat;
  logic [1:0]       rbusy;
  logic [1:0]       wen;
  logic [1:0][4:0]  wsel;
  logic [1:0][31:0] wdat;
  logic [1:0]       wclr;
  logic [1:0][3:0]  wtag;
  logic             rsv_en;
  logic [4:0]       rsv_sel;
  logic [3:0]       rsv_tag;
  logic             flush;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard #(.DW(32), .NREGS(32), .NRD(2), .NWR(2), .TAGW(4)) dut (
    .CLK(CLK), .nRST(nRST), .rsel(rsel), .rdat(rdat), .rbusy(rbusy),
    .wen(wen), .wsel(wsel), .wdat(wdat), .wclr(wclr), .wtag(wtag),
    .rsv_en(rsv_en), .rsv_sel(rsv_sel), .rsv_tag(rsv_tag), .flush(flush)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  rs0, rs1;
    logic [1:0]  wen;
    logic [4:0]  ws0;
    logic [31:0] wd0;
    logic [4:0]  ws1;
    logic [31:0] wd1;
    logic [1:0]  wclr;
    logic [3:0]  wt0, wt1;
    logic        rsv_en;
    logic [4:0]  rsv_sel;
    logic [3:0]  rsv_tag;
    logic        flush;
    logic [31:0] e0, e1;
    logic [1:0]  eb;  // {rbusy[1], rbusy[0]}
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic [4:0] rs0, logic [4:0] rs1, logic [1:0] we,
    logic [4:0] ws0, logic [31:0] wd0, logic [4:0] ws1, logic [31:0] wd1,
    logic [1:0] wc, logic [3:0] wt0, logic [3:0] wt1,
    logic re, logic [4:0] rs, logic [3:0] rt, logic fl,
    logic [31:0] e0, logic [31:0] e1, logic [1:0] eb);
    vec_t v;
    v.rs0 = rs0; v.rs1 = rs1; v.wen = we; v.ws0 = ws0; v.wd0 = wd0;
    v.ws1 = ws1; v.wd1 = wd1; v.wclr = wc; v.wt0 = wt0; v.wt1 = wt1;
    v.rsv_en = re; v.rsv_sel = rs; v.rsv_tag = rt; v.flush = fl;
    v.e0 = e0; v.e1 = e1; v.eb = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wen = '0; wsel = '0; wdat = '0; wclr = '0; wtag = '0;
    rsv_en = 1'b0; rsv_sel = '0; rsv_tag = '0; flush = 1'b0;
  endtask

  initial begin
    nRST = 1'b0;
    rsel = '0;
    idle_inputs();

    // Reset: every register reads zero and idle on both ports.
    #2;
    for (int k = 0; k < 32; k++) begin
      rsel[0] = 5'(k); rsel[1] = 5'(31 - k);
      #1;
      chk($sformatf("rst_rdat0_r%0d", k), rdat[0], 32'h0);
      chk($sformatf("rst_rdat1_r%0d", 31 - k), rdat[1], 32'h0);
      chk($sformatf("rst_rbusy_r%0d", k), {30'h0, rbusy}, 32'h0);
    end
    @(negedge CLK);
    nRST = 1'b1;

    //        rs0 rs1 wen ws0 wd0           ws1 wd1       wclr wt0 wt1 rsv sel tag fl  e0            e1            eb
    tbl.push_back(mk(0, 1, 2'b00, 0, 0,            0, 0,        2'b00, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        2'b00));
    tbl.push_back(mk(3, 3, 2'b01, 3, 32'hDEADBEEF, 0, 0,        2'b00, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00));
    tbl.push_back(mk(3, 0, 2'b00, 0, 0,            0, 0,        2'b00, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0,        2'b00));
    tbl.push_back(mk(0, 3, 2'b01, 0, 32'h1234,     0, 0,        2'b00, 0, 0, 0, 0, 0, 0, 32'h0,        32'hDEADBEEF, 2'b00));
    tbl.push_back(mk(0, 7, 2'b00, 0, 0,            0, 0,        2'b00, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        2'b00));
    tbl.push_back(mk(7, 3, 2'b11, 7, 32'h11,       7, 32'h22,   2'b00, 0, 0, 0, 0, 0, 0, 32'h22,       32'hDEADBEEF, 2'b00));
    tbl.push_back(mk(7, 4, 2'b00, 0, 0,            0, 0,        2'b00, 0, 0, 1, 4, 3, 0, 32'h22,       32'h0,        2'b00));
    tbl.push_back(mk(4, 4, 2'b01, 4, 32'hAAAA,     0, 0,        2'b01, 2, 0, 0, 0, 0, 0, 32'hAAAA,     32'hAAAA,     2'b11));
    tbl.push_back(mk(4, 4, 2'b10, 0, 0,            4, 32'hBBBB, 2'b10, 0, 3, 0, 0, 0, 0, 32'hBBBB,     32'hBBBB,     2'b00));
    tbl.push_back(mk(4, 0, 2'b00, 0, 0,            0, 0,        2'b00, 0, 0, 0, 0, 0, 0, 32'hBBBB,     32'h0,        2'b00));
    tbl.push_back(mk(9, 9, 2'b00, 0, 0,            0, 0,        2'b00, 0, 0, 1, 9, 5, 0, 32'h0,        32'h0,        2'b00));
    tbl.push_back(mk(9, 9, 2'b01, 9, 32'h99,       0, 0,        2'b01, 5, 0, 1, 9, 5, 0, 32'h99,       32'h99,       2'b11));
    tbl.push_back(mk(9, 9, 2'b01, 9, 32'h9A,       0, 0,        2'b01, 5, 0, 1, 9, 6, 0, 32'h9A,       32'h9A,       2'b11));
    tbl.push_back(mk(9, 9, 2'b01, 9, 32'h9B,       0, 0,        2'b01, 5, 0, 0, 0, 0, 0, 32'h9B,       32'h9B,       2'b11));
    tbl.push_back(mk(9, 9, 2'b00, 0, 0,            9, 32'hEE,   2'b10, 0, 6, 0, 0, 0, 0, 32'h9B,       32'h9B,       2'b11));
    tbl.push_back(mk(9, 9, 2'b10, 0, 0,            9, 32'h9C,   2'b10, 0, 6, 0, 0, 0, 0, 32'h9C,       32'h9C,       2'b00));
    tbl.push_back(mk(9, 0, 2'b00, 0, 0,            0, 0,        2'b00, 0, 0, 0, 0, 0, 0, 32'h9C,       32'h0,        2'b00));
    tbl.push_back(mk(1, 9, 2'b00, 0, 0,            0, 0,        2'b00, 0, 0, 1, 1, 1, 0, 32'h0,        32'h9C,       2'b00));
    tbl.push_back(mk(1, 2, 2'b00, 0, 0,            0, 0,        2'b00, 0, 0, 1, 2, 2, 0, 32'h0,        32'h0,        2'b01));
    tbl.push_back(mk(1, 2, 2'b00, 0, 0,            0, 0,        2'b00, 0, 0, 1, 3, 3, 0, 32'h0,        32'h0,        2'b11));
    tbl.push_back(mk(3, 8, 2'b01, 5, 32'h5555,     0, 0,        2'b00, 0, 0, 1, 8, 8, 1, 32'hDEADBEEF, 32'h0,        2'b01));
    tbl.push_back(mk(1, 8, 2'b00, 0, 0,            0, 0,        2'b00, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        2'b10));
    tbl.push_back(mk(2, 3, 2'b00, 0, 0,            0, 0,        2'b00, 0, 0, 0, 0, 0, 0, 32'h0,        32'hDEADBEEF, 2'b00));
    tbl.push_back(mk(5, 7, 2'b00, 0, 0,            0, 0,        2'b00, 0, 0, 0, 0, 0, 0, 32'h5555,     32'h22,       2'b00));

    foreach (tbl[n]) begin
      @(negedge CLK);
      rsel[0] = tbl[n].rs0; rsel[1] = tbl[n].rs1;
      wen = tbl[n].wen;
      wsel[0] = tbl[n].ws0; wdat[0] = tbl[n].wd0;
      wsel[1] = tbl[n].ws1; wdat[1] = tbl[n].wd1;
      wclr = tbl[n].wclr; wtag[0] = tbl[n].wt0; wtag[1] = tbl[n].wt1;
      rsv_en = tbl[n].rsv_en; rsv_sel = tbl[n].rsv_sel; rsv_tag = tbl[n].rsv_tag;
      flush = tbl[n].flush;
      #1;
      chk($sformatf("vec%0d_rdat0", n), rdat[0], tbl[n].e0);
      chk($sformatf("vec%0d_rdat1", n), rdat[1], tbl[n].e1);
      chk($sformatf("vec%0d_rbusy", n), {30'h0, rbusy}, {30'h0, tbl[n].eb});
    end

    // Reset asserted in the middle of a write to r5 (which holds 5555).
    @(negedge CLK);
    idle_inputs();
    rsel[0] = 5'd5; rsel[1] = 5'd7;
    wen = 2'b01; wsel[0] = 5'd5; wdat[0] = 32'hAAAA5;
    #1;
    chk("midrst_bypass_r5", rdat[0], 32'hAAAA5);
    #1;
    nRST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    wen = '0;
    nRST = 1'b1;
    #1;
    chk("midrst_r5", rdat[0], 32'h0);
    chk("midrst_r7", rdat[1], 32'h0);
    @(negedge CLK);
    rsel[0] = 5'd8; rsel[1] = 5'd3;
    #1;
    chk("midrst_busy", {30'h0, rbusy}, 32'h0);
    chk("midrst_r3", rdat[1], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
